// File: rtl/fpro_bus_arbiter_if.sv
// Signal bundle around fpro_bus_arbiter: MCS IO bus, secondary master port
// (m1) and the shared FPro MMIO bus. master = the arbiter itself,
// slave = the MCS core, the m1 engine and the MMIO slot controller.
interface fpro_bus_arbiter_if;
  // MCS IO bus
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_read_data;
  logic        io_ready;
  // secondary master
  logic        m1_req;
  logic        m1_wr;
  logic [20:0] m1_addr;
  logic [31:0] m1_wr_data;
  logic        m1_ack;
  logic [31:0] m1_rd_data;
  // FPro MMIO bus
  logic        fp_mmio_cs;
  logic        fp_wr;
  logic        fp_rd;
  logic [20:0] fp_addr;
  logic [31:0] fp_wr_data;
  logic [31:0] fp_rd_data;

  modport master (
    input  io_addr_strobe, io_read_strobe, io_write_strobe, io_address,
           io_write_data, io_byte_enable,
    output io_read_data, io_ready,
    input  m1_req, m1_wr, m1_addr, m1_wr_data,
    output m1_ack, m1_rd_data,
    output fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    input  fp_rd_data
  );

  modport slave (
    output io_addr_strobe, io_read_strobe, io_write_strobe, io_address,
           io_write_data, io_byte_enable,
    input  io_read_data, io_ready,
    output m1_req, m1_wr, m1_addr, m1_wr_data,
    input  m1_ack, m1_rd_data,
    input  fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    output fp_rd_data
  );
endinterface

// File: rtl/fpro_bus_arbiter.sv
// Two-master arbiter for the FPro MMIO bus: MCS IO bus (strobed, latched
// into a pending register) and a level-request secondary master m1.
// Round-robin on ties, one registered IDLE/BUS/RESP sequence per transaction.
module fpro_bus_arbiter #(
  parameter logic [31:0] BRG_BASE = 32'hC000_0000
) (
  input  logic               clk,
  input  logic               reset,
  fpro_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_n;

  // pending MCS request
  logic        mcs_pend, pend_wr, pend_miss;
  logic [20:0] pend_addr;
  logic [31:0] pend_data;
  // granted transaction; last_m1 = 1 means m1 won the previous grant
  logic        gnt_m1, txn_wr, last_m1;

  logic        strobe_ok, strobe_hit, any_req, pick_m1, grant_bus, go_wr;
  logic [31:0] rd_val;

  // next values of the registered outputs
  logic        cs_n, wr_n, rd_n, io_ready_n, m1_ack_n;
  logic [20:0] fp_addr_n;
  logic [31:0] fp_wr_data_n, io_read_data_n, m1_rd_data_n;

  // byte enables and the byte offset play no part: all accesses are words
  logic unused_ok;
  assign unused_ok = ^{bus.io_byte_enable, bus.io_address[1:0]};

  assign strobe_ok  = bus.io_addr_strobe & (bus.io_read_strobe | bus.io_write_strobe);
  assign strobe_hit = (bus.io_address[31:24] == BRG_BASE[31:24]) & ~bus.io_address[23];
  assign any_req    = mcs_pend | bus.m1_req;
  // on a tie the master that did not win last time goes first
  assign pick_m1    = bus.m1_req & (~mcs_pend | ~last_m1);
  // only an MCS decode miss skips the bus cycle
  assign grant_bus  = any_req & (pick_m1 | ~pend_miss);
  assign go_wr      = pick_m1 ? bus.m1_wr : pend_wr;
  assign rd_val     = txn_wr ? 32'h0 : bus.fp_rd_data;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = grant_bus ? BUS : RESP;
      BUS:     state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // MCS capture, grant latch and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      mcs_pend  <= 1'b0;
      pend_wr   <= 1'b0;
      pend_miss <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      gnt_m1    <= 1'b0;
      txn_wr    <= 1'b0;
      last_m1   <= 1'b1;
    end else begin
      if (state == RESP && !gnt_m1) begin
        mcs_pend <= 1'b0;
      end else if (!mcs_pend && strobe_ok) begin
        mcs_pend  <= 1'b1;
        pend_wr   <= bus.io_write_strobe;
        pend_miss <= ~strobe_hit;
        pend_addr <= bus.io_address[22:2];
        pend_data <= bus.io_write_data;
      end
      if (state == IDLE && any_req) begin
        gnt_m1 <= pick_m1;
        txn_wr <= go_wr;
      end
      if (state == RESP) last_m1 <= gnt_m1;
    end
  end

  // output decode: values the output registers take on the coming edge
  always_comb begin
    cs_n           = 1'b0;
    wr_n           = 1'b0;
    rd_n           = 1'b0;
    io_ready_n     = 1'b0;
    m1_ack_n       = 1'b0;
    fp_addr_n      = bus.fp_addr;
    fp_wr_data_n   = bus.fp_wr_data;
    io_read_data_n = bus.io_read_data;
    m1_rd_data_n   = bus.m1_rd_data;
    case (state)
      IDLE: begin
        if (grant_bus) begin
          cs_n         = 1'b1;
          wr_n         = go_wr;
          rd_n         = ~go_wr;
          fp_addr_n    = pick_m1 ? bus.m1_addr : pend_addr;
          fp_wr_data_n = pick_m1 ? bus.m1_wr_data : pend_data;
        end else if (any_req) begin
          io_ready_n     = 1'b1;
          io_read_data_n = 32'h0;
        end
      end
      BUS: begin
        if (gnt_m1) begin
          m1_ack_n     = 1'b1;
          m1_rd_data_n = rd_val;
        end else begin
          io_ready_n     = 1'b1;
          io_read_data_n = rd_val;
        end
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.fp_mmio_cs   <= 1'b0;
      bus.fp_wr        <= 1'b0;
      bus.fp_rd        <= 1'b0;
      bus.fp_addr      <= '0;
      bus.fp_wr_data   <= '0;
      bus.io_ready     <= 1'b0;
      bus.io_read_data <= '0;
      bus.m1_ack       <= 1'b0;
      bus.m1_rd_data   <= '0;
    end else begin
      bus.fp_mmio_cs   <= cs_n;
      bus.fp_wr        <= wr_n;
      bus.fp_rd        <= rd_n;
      bus.fp_addr      <= fp_addr_n;
      bus.fp_wr_data   <= fp_wr_data_n;
      bus.io_ready     <= io_ready_n;
      bus.io_read_data <= io_read_data_n;
      bus.m1_ack       <= m1_ack_n;
      bus.m1_rd_data   <= m1_rd_data_n;
    end
  end
endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Bench for fpro_bus_arbiter: directed MCS vector table, hand-written m1,
// tie, reset and contention sequences, then randomized traffic from both
// masters checked against a transaction-level model.
module tb_fpro_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpro_bus_arbiter_if bus();
  fpro_bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave: fixed value for directed tests, address hash otherwise
  logic        use_fixed = 1'b1;
  logic [31:0] fixed_data = 32'h0;
  function automatic logic [31:0] slave_fn(input logic [20:0] a);
    return {a[10:0], a} ^ 32'h5A5A_C3C3;
  endfunction
  assign bus.fp_rd_data = !bus.fp_rd ? 32'h0 : (use_fixed ? fixed_data : slave_fn(bus.fp_addr));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // event counters and the per-master outstanding-request model
  int   n_bus = 0, n_rdy = 0, n_ack = 0;
  logic sb_on = 1'b0;
  logic        mcs_exp_v = 1'b0, m1_exp_v = 1'b0, mcs_exp_w, m1_exp_w;
  logic [20:0] mcs_exp_a, m1_exp_a;
  logic [31:0] mcs_exp_d, m1_exp_d;
  int   mcs_bussed, m1_bussed;
  int   order[$];

  always @(negedge clk) begin
    if (bus.io_ready) n_rdy++;
    if (bus.m1_ack) n_ack++;
    if (bus.fp_mmio_cs) begin
      n_bus++;
      if (sb_on) begin
        chk("bus_one_strobe", bus.fp_rd ^ bus.fp_wr, 1);
        n_cmp++;
        if (mcs_exp_v && bus.fp_addr == mcs_exp_a && bus.fp_wr == mcs_exp_w &&
            (!mcs_exp_w || bus.fp_wr_data == mcs_exp_d)) begin
          mcs_exp_v = 1'b0; mcs_bussed++;
        end else if (m1_exp_v && bus.fp_addr == m1_exp_a && bus.fp_wr == m1_exp_w &&
                     (!m1_exp_w || bus.fp_wr_data == m1_exp_d)) begin
          m1_exp_v = 1'b0; m1_bussed++;
        end else begin
          n_bad++;
          $display("FAIL bus_match: got addr %0h wr %0b data %0h, no outstanding request expects it",
                   bus.fp_addr, bus.fp_wr, bus.fp_wr_data);
        end
      end
    end else if (sb_on) begin
      chk("bus_idle_strobes", {bus.fp_rd, bus.fp_wr}, 0);
    end
  end

  task automatic mcs_strobe(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.io_addr_strobe = 1'b1; bus.io_write_strobe = w; bus.io_read_strobe = ~w;
    bus.io_address = a; bus.io_write_data = d; bus.io_byte_enable = 4'($urandom);
  endtask
  task automatic mcs_idle();
    bus.io_addr_strobe = 1'b0; bus.io_write_strobe = 1'b0; bus.io_read_strobe = 1'b0;
    bus.io_address = $urandom; bus.io_write_data = $urandom;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic        hit;
    logic [20:0] fa;
    logic [31:0] rd;
  } vec_t;
  vec_t vt[8];
  logic [20:0] last_fa = '0;

  // one MCS transaction with a cycle-by-cycle check of the strobe timing
  task automatic apply_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("vec%0d", i);
    use_fixed = 1'b1; fixed_data = v.sdata;
    mcs_strobe(v.addr, v.wr, v.wdata);
    @(negedge clk); chk({p, "_c0"}, {bus.fp_mmio_cs, bus.io_ready}, 0);
    @(posedge clk); #1; mcs_idle();
    @(negedge clk); chk({p, "_c1"}, {bus.fp_mmio_cs, bus.io_ready}, 0);
    @(negedge clk);
    if (v.hit) begin
      chk({p, "_c2_strobes"}, {bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd}, {1'b1, v.wr, ~v.wr});
      chk({p, "_c2_addr"}, bus.fp_addr, v.fa);
      if (v.wr) chk({p, "_c2_wdata"}, bus.fp_wr_data, v.wdata);
      chk({p, "_c2_ready"}, bus.io_ready, 0);
      @(negedge clk);
      chk({p, "_c3_strobes"}, {bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd}, 0);
      chk({p, "_c3_ready"}, bus.io_ready, 1);
      chk({p, "_c3_data"}, bus.io_read_data, v.rd);
      chk({p, "_c3_addr_hold"}, bus.fp_addr, v.fa);
      last_fa = v.fa;
    end else begin
      chk({p, "_miss_strobes"}, {bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd}, 0);
      chk({p, "_miss_ready"}, bus.io_ready, 1);
      chk({p, "_miss_data"}, bus.io_read_data, 0);
      chk({p, "_miss_addr_hold"}, bus.fp_addr, last_fa);
    end
    @(negedge clk);
    chk({p, "_after_ready"}, bus.io_ready, 0);
    chk({p, "_after_data_hold"}, bus.io_read_data, v.rd);
    @(posedge clk); #1;
  endtask

  // one m1 transaction; with drop, m1_req and its fields change right after grant
  task automatic m1_seq(input string p, input logic w, input logic [20:0] a,
                        input logic [31:0] d, input logic [31:0] s, input bit drop);
    int b0, k0;
    use_fixed = 1'b1; fixed_data = s; b0 = n_bus; k0 = n_ack;
    bus.m1_req = 1'b1; bus.m1_wr = w; bus.m1_addr = a; bus.m1_wr_data = d;
    @(negedge clk); chk({p, "_c0"}, {bus.fp_mmio_cs, bus.m1_ack}, 0);
    @(posedge clk); #1;
    if (drop) begin
      bus.m1_req = 1'b0; bus.m1_wr = ~w; bus.m1_addr = 21'($urandom); bus.m1_wr_data = $urandom;
    end
    @(negedge clk);
    chk({p, "_c1_strobes"}, {bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd}, {1'b1, w, ~w});
    chk({p, "_c1_addr"}, bus.fp_addr, a);
    if (w) chk({p, "_c1_wdata"}, bus.fp_wr_data, d);
    chk({p, "_c1_ack"}, bus.m1_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({p, "_c2_ack"}, bus.m1_ack, 1);
    chk({p, "_c2_data"}, bus.m1_rd_data, w ? 32'h0 : s);
    chk({p, "_c2_cs"}, bus.fp_mmio_cs, 0);
    @(posedge clk); #1; bus.m1_req = 1'b0;
    repeat (4) @(negedge clk);
    chk({p, "_bus_once"}, n_bus - b0, 1);
    chk({p, "_ack_once"}, n_ack - k0, 1);
    @(posedge clk); #1;
  endtask

  // MCS traffic source; expected results come from the decode rule and the slave
  task automatic mcs_drive(input int n, input int gmax, input bit contend);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a, d, exp_rd;
      logic w, hit;
      int t0, lat, sel;
      bit done;
      repeat ($urandom_range(gmax, 0)) begin @(posedge clk); #1; end
      a = $urandom; a[1:0] = 2'b00;
      sel = $urandom_range(3, 0);
      if (contend || sel < 2) a[31:23] = {8'hC0, 1'b0};
      else if (sel == 2)      a[31:23] = {8'hC0, 1'b1};
      w = contend ? 1'b1 : 1'($urandom);
      d = $urandom;
      hit = (a[31:24] == 8'hC0) && !a[23];
      exp_rd = (hit && !w) ? slave_fn(a[22:2]) : 32'h0;
      mcs_exp_v = hit; mcs_exp_a = a[22:2]; mcs_exp_w = w; mcs_exp_d = d; mcs_bussed = 0;
      mcs_strobe(a, w, d);
      t0 = cyc;
      @(posedge clk); #1; mcs_idle();
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (bus.io_ready) done = 1;
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL mcs_timeout: got no io_ready within 20 cycles, required one");
      end else begin
        lat = cyc - t0;
        chk("mcs_rdata", bus.io_read_data, exp_rd);
        chk("mcs_latency", (lat >= (hit ? 3 : 2)) && (lat <= (hit ? 6 : 5)), 1);
        chk("mcs_bus_count", mcs_bussed, hit ? 1 : 0);
      end
      order.push_back(0);
      @(posedge clk); #1;
    end
  endtask

  // m1 traffic source; request held until ack
  task automatic m1_drive(input int n, input int gmax, input bit contend);
    for (int k = 0; k < n; k++) begin
      logic [20:0] a;
      logic [31:0] d;
      logic w;
      int t0, lat;
      bit done;
      repeat ($urandom_range(gmax, 0)) begin @(posedge clk); #1; end
      a = contend ? 21'h00000A : 21'($urandom);
      w = contend ? 1'b0 : 1'($urandom);
      d = $urandom;
      m1_exp_v = 1'b1; m1_exp_a = a; m1_exp_w = w; m1_exp_d = d; m1_bussed = 0;
      bus.m1_req = 1'b1; bus.m1_wr = w; bus.m1_addr = a; bus.m1_wr_data = d;
      t0 = cyc;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (bus.m1_ack) done = 1;
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL m1_timeout: got no m1_ack within 20 cycles, required one");
      end else begin
        lat = cyc - t0;
        chk("m1_rdata", bus.m1_rd_data, w ? 32'h0 : slave_fn(a));
        chk("m1_latency", (lat >= 2) && (lat <= 5), 1);
        chk("m1_bus_count", m1_bussed, 1);
      end
      order.push_back(1);
      @(posedge clk); #1;
      bus.m1_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    vt[0] = '{32'hC000_0010, 1'b1, 32'h1234_5678, 32'h0,         1'b1, 21'h000004, 32'h0};
    vt[1] = '{32'hC000_0100, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b1, 21'h000040, 32'hDEAD_BEEF};
    vt[2] = '{32'h8000_0000, 1'b0, 32'h0,         32'h1111_1111, 1'b0, 21'h0,      32'h0};
    vt[3] = '{32'hC080_0000, 1'b0, 32'h0,         32'h2222_2222, 1'b0, 21'h0,      32'h0};
    vt[4] = '{32'hC07F_FFFC, 1'b1, 32'hAAAA_5555, 32'h0,         1'b1, 21'h1FFFFF, 32'h0};
    vt[5] = '{32'hC000_0000, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b1, 21'h000000, 32'hFFFF_FFFF};
    vt[6] = '{32'hC000_0008, 1'b0, 32'h0,         32'h0000_0001, 1'b1, 21'h000002, 32'h0000_0001};
    vt[7] = '{32'hC100_0000, 1'b1, 32'h0BAD_F00D, 32'h0,         1'b0, 21'h0,      32'h0};

    reset = 1'b1;
    mcs_idle(); bus.io_byte_enable = 4'h0;
    bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd, bus.fp_addr, bus.fp_wr_data,
        bus.io_ready, bus.io_read_data, bus.m1_ack, bus.m1_rd_data}, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {bus.fp_mmio_cs, bus.io_ready, bus.m1_ack}, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) apply_vec(i, vt[i]);

    m1_seq("m1_read_drop", 1'b0, 21'h00000A, 32'h0, 32'hCAFE_0001, 1'b1);
    m1_seq("m1_write", 1'b1, 21'h1ABCDE, 32'h0F0F_3C3C, 32'h0, 1'b0);

    // simultaneous MCS strobe and m1_req: m1 first, then MCS
    use_fixed = 1'b1; fixed_data = 32'h1111_2222;
    mcs_strobe(32'hC000_0020, 1'b0, 32'h0);
    bus.m1_req = 1'b1; bus.m1_wr = 1'b1; bus.m1_addr = 21'h000155; bus.m1_wr_data = 32'h0000_600D;
    @(posedge clk); #1; mcs_idle();
    @(negedge clk);
    chk("tie_c1_m1_bus", {bus.fp_mmio_cs, bus.fp_wr, bus.fp_addr}, {2'b11, 21'h000155});
    @(negedge clk);
    chk("tie_c2_ack", {bus.m1_ack, bus.io_ready}, 2'b10);
    @(posedge clk); #1; bus.m1_req = 1'b0;
    @(negedge clk); chk("tie_c3_idle", bus.fp_mmio_cs, 0);
    @(negedge clk);
    chk("tie_c4_mcs_bus", {bus.fp_mmio_cs, bus.fp_rd, bus.fp_addr}, {2'b11, 21'h000008});
    @(negedge clk);
    chk("tie_c5_ready", {bus.io_ready, bus.io_read_data}, {1'b1, 32'h1111_2222});
    @(posedge clk); #1;

    // reset during the BUS cycle of an MCS read
    use_fixed = 1'b1; fixed_data = 32'h7777_8888; r0 = n_rdy;
    mcs_strobe(32'hC000_0040, 1'b0, 32'h0);
    @(posedge clk); #1; mcs_idle();
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk); chk("rst_in_bus_cycle", {bus.fp_mmio_cs, bus.fp_rd}, 2'b11);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {bus.fp_mmio_cs, bus.fp_wr, bus.fp_rd, bus.fp_addr, bus.fp_wr_data,
        bus.io_ready, bus.io_read_data, bus.m1_ack, bus.m1_rd_data}, 0);
    repeat (4) @(negedge clk);
    chk("rst_mid_no_ready", n_rdy - r0, 0);
    @(posedge clk); #1;
    last_fa = '0;
    apply_vec(100, vt[1]);

    // sustained contention: grants must alternate
    use_fixed = 1'b0; sb_on = 1'b1;
    order.delete();
    fork
      mcs_drive(10, 0, 1'b1);
      m1_drive(10, 0, 1'b1);
    join
    chk("contend_count", order.size(), 20);
    for (int k = 1; k < order.size(); k++)
      chk($sformatf("contend_alt%0d", k), order[k] != order[k-1], 1);

    // randomized traffic from both masters
    fork
      mcs_drive(60, 3, 1'b0);
      m1_drive(60, 3, 1'b0);
    join
    sb_on = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpro_bus_arbiter.md
# fpro_bus_arbiter

Shares the single FPro MMIO bus (fp_mmio_cs/fp_wr/fp_rd/fp_addr/fp_wr_data/fp_rd_data) between two masters: the MicroBlaze MCS IO bus and one secondary master port (m1, e.g. a DMA or test engine). It latches strobed MCS requests, decodes the bridge window, arbitrates round-robin, sequences one registered bus cycle per transaction, and returns read data through the correct master's handshake. It sits between the MCS core and the MMIO slot controller in fpro_system.

## Interface
- BRG_BASE, 32'hC000_0000: MCS bridge base; MCS hit when io_address[31:24] == BRG_BASE[31:24] and io_address[23] == 0.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- io_addr_strobe  in  1  MCS request strobe, one-cycle pulse.
- io_read_strobe / io_write_strobe  in  1 each  qualify io_addr_strobe.
- io_address  in  32  MCS byte address, valid only in strobe cycle.
- io_write_data  in  32  MCS write data, valid only in strobe cycle.
- io_byte_enable  in  4  ignored; all accesses are full 32-bit words.
- io_read_data  out  32  MCS read data, valid when io_ready = 1.
- io_ready  out  1  one-cycle MCS completion pulse.
- m1_req  in  1  secondary request level; held until m1_ack.
- m1_wr  in  1  1 = write, 0 = read.
- m1_addr  in  21  secondary word address.
- m1_wr_data  in  32  secondary write data.
- m1_ack  out  1  one-cycle secondary completion pulse.
- m1_rd_data  out  32  secondary read data, valid when m1_ack = 1.
- fp_mmio_cs, fp_wr, fp_rd  out  1 each  FPro bus strobes.
- fp_addr  out  21  FPro word address.
- fp_wr_data  out  32  FPro write data.
- fp_rd_data  in  32  FPro read data; combinational from slave, valid in the strobe cycle.

## Operation
- MCS capture: on io_addr_strobe with read or write strobe, latch address, data and direction into the pending register; set mcs_pend. The hit/miss decode is registered with the request. fp_addr for MCS = io_address[22:2].
- A strobe while mcs_pend = 1 is ignored.
- m1 is sampled only in IDLE. Once granted, its fields are latched and the transaction completes and acks even if m1_req drops.
- FSM states:
  - IDLE: if mcs_pend and/or m1_req, grant. On a tie, grant the master not in last_grant. Load bus output registers. Go to BUS, or to RESP directly for an MCS decode miss.
  - BUS: fp_mmio_cs = 1 and exactly one of fp_rd/fp_wr = 1, for exactly one cycle. On a read, capture fp_rd_data into rd_buf. Go to RESP.
  - RESP: pulse io_ready or m1_ack for the granted master. Drive read data: rd_buf on a read; 0 on a write or on a miss. Clear mcs_pend if MCS was granted. Update last_grant. Go to IDLE.
- io_read_data and m1_rd_data hold their last value between completions.
- fp_addr/fp_wr_data hold their last value outside BUS. fp_mmio_cs/fp_wr/fp_rd are 0 outside BUS.
- Reset values:
  - All outputs 0; state IDLE; mcs_pend 0.
  - last_grant = m1, so MCS wins the first tie.
- Reset mid-transaction: a pending or in-flight request is dropped; no io_ready or m1_ack is produced.

## Timing
- All outputs are registered.
- MCS hit, bus idle: strobe in cycle 0, fp_mmio_cs in cycle 2, io_ready and io_read_data in cycle 3.
- MCS miss: strobe in cycle 0, io_ready with data 0 in cycle 2, no bus cycle.
- m1, bus idle: m1_req first high in cycle 0 (IDLE), bus strobe in cycle 1, m1_ack in cycle 2.
- Throughput: one bus transaction per 3 cycles. IDLE lasts at least one cycle between transactions.
- Contention: the loser waits at most one transaction (3 cycles) plus its own 3.
- Simultaneous MCS strobe and m1_req in IDLE: m1 is granted, because mcs_pend is not yet set. The MCS request is then granted next.

## Test plan
- MCS write: strobe, write, io_address C000_0010, data 1234_5678 -> cycle 2: fp_mmio_cs = fp_wr = 1, fp_addr = 0x000004, fp_wr_data = 1234_5678; cycle 3: io_ready = 1, io_read_data = 0.
- MCS read: io_address C000_0100, slave drives fp_rd_data = DEAD_BEEF when fp_rd = 1 -> fp_addr = 0x000040 in cycle 2; io_ready with io_read_data = DEAD_BEEF in cycle 3.
- Decode miss: io_address 8000_0000, then C080_0000 -> no fp strobe; io_ready in cycle 2 with data 0 each time.
- Contention: m1_req held continuously with read of 0x00000A, MCS writes back-to-back -> grants alternate m1/MCS; each completion matches its own data; no starvation over 20 transactions.
- Reset mid-op: assert reset in the BUS cycle of an MCS read -> next cycle all outputs 0, no io_ready; a subsequent MCS request completes normally.
- m1 drop: m1_req deasserted the cycle after grant -> bus cycle and m1_ack still occur exactly once.
